spatz_lane_sequencer: RTL and testbench
=======================================

SPATZ_LANE_SEQUENCER -- requirements
Module: spatz_lane_sequencer

Interface
REQ-001 SHALL have parameter Width, default 32; the lane element width in bits.
REQ-002 SHALL have parameter MaxVl, default 256; the maximum element count per request. VlW = $clog2(MaxVl+1).
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 req_valid_i / req_ready_o  in/out  1  handshake for operation requests.
REQ-006 req_op_i  in  op_e  operation; req_vl_i  in  VlW  element count; req_sew_i  in  rvv_pkg::vew_e  element width; req_signed_i  in  1  signedness.
REQ-007 opd_valid_i / opd_ready_o  in/out  1  handshake for the operand stream, one element per handshake.
REQ-008 opd_s1_i, opd_s2_i, opd_d_i  in  Width  operands; opd_carry_i  in  1  carry/borrow input.
REQ-009 lane_op_o  out  op_e; lane_s1_o, lane_s2_o, lane_d_o  out  Width; lane_signed_o, lane_carry_o  out  1; lane_sew_o  out  vew_e. All drive the combinational SIMD lane.
REQ-010 lane_result_i  in  Width  lane result, combinational from the lane_* outputs.
REQ-011 res_valid_o / res_ready_i  out/in  1  result handshake; res_data_o  out  Width; res_last_o  out  1  marks the final element.
REQ-012 done_o  out  1  one-cycle pulse on request completion.
REQ-013 perf_stall_o  out  32  backpressure stall counter (see Configuration).

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-015 IDLE: req_ready_o=1, and opd_ready_o=0. On a request handshake, latch op, sew and signed; load the remaining-element counter with req_vl_i; go to RUN.
REQ-016 A request handshake with req_vl_i=0 SHALL stay in IDLE, pulse done_o in the next cycle, and produce no results.
REQ-017 RUN: opd_ready_o = !res_valid_o || res_ready_i. The output register accepts a new value in the same cycle that it drains.
REQ-018 Lane outputs SHALL be driven combinationally: latched op, sew and signed, plus the current opd_* values. The op is held while not in RUN.
REQ-019 On an operand handshake: capture lane_result_i into res_data_o; set res_valid_o on the next edge (latency 1 cycle); decrement the counter.
REQ-020 res_last_o SHALL be registered with the data; it is 1 only when the captured element had counter == 1.
REQ-021 After the last operand handshake, SHALL go to DRAIN. In DRAIN, opd_ready_o=0.
REQ-022 DRAIN → IDLE on the res_last_o handshake; done_o pulses in that same transition cycle. req_ready_o is 0 in DRAIN.
REQ-023 res_data_o and res_last_o SHALL be stable while res_valid_o=1 and res_ready_i=0.
REQ-024 A new request SHALL NOT be accepted until the previous request's last result has completed its handshake.
REQ-025 Requests with req_vl_i > MaxVl are undefined; an assertion SHALL flag them.

Reset
REQ-026 On rst_ni=0, regardless of state: state=IDLE, counter=0, res_valid_o=0, res_last_o=0, res_data_o=0, done_o=0, perf_stall_o=0, latched op=VADD, sew=EW_8, signed=0.
REQ-027 Reset asserted mid-request SHALL discard all in-flight state; no result is emitted after deassertion.

Configuration
REQ-028 Macro SPATZ_SEQ_PERF_EN defined: perf_stall_o SHALL count cycles in RUN with opd_valid_i=1 and opd_ready_o=0. The count saturates at 2^32-1 and clears only on reset.
REQ-029 Macro SPATZ_SEQ_PERF_EN undefined: perf_stall_o is tied to 0 and no counter flops exist.

Structure
REQ-030 The seq_state_e enum (IDLE, RUN, DRAIN) SHALL reside in spatz_pkg; op_e and vew_e are reused unchanged.
REQ-031 The output register (data, last, valid, with stall hold) SHALL be one sub-module, spatz_seq_outreg. Everything else is in the top module.

Verification
REQ-032 Request VADD, vl=4, Width=32, s1={1,2,3,4}, s2={10,20,30,40}, res_ready_i=1 → results 11,22,33,44 on consecutive cycles, res_last_o only on 44, done_o one cycle after 44's handshake.
REQ-033 Same stream with res_ready_i toggling 1,0,0,1,... → no lost or duplicated element; data held during stalls; perf_stall_o increments once per stalled cycle when SPATZ_SEQ_PERF_EN is defined.
REQ-034 Request vl=0 → no res_valid_o; done_o pulses once; the next request is accepted in the following cycle.
REQ-035 VMULHU, vl=1, s1=0xFFFFFFFF, s2=2 → res_data_o=0x00000001 with res_last_o=1; lane_signed_o=0 throughout.
REQ-036 Assert rst_ni=0 after 2 of 4 elements are accepted → all outputs return to reset values asynchronously; after release, req_ready_o=1 and no stale results appear.
REQ-037 Two back-to-back requests (vl=2, then vl=3) with req_valid_i held high → the second is accepted only after the first's last handshake; results arrive in order, with 2 and then 3 last flags.

Source files
------------

// File: rtl/rvv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// rvv_pkg: vector element-width encoding shared across the vector unit.
// Rev 1.0
// ------------------------------------------------------------------------
package rvv_pkg;

    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

endpackage : rvv_pkg
`default_nettype wire

// File: rtl/spatz_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// spatz_pkg: lane operation codes and lane-sequencer state encoding.
// Rev 1.0
// ------------------------------------------------------------------------
package spatz_pkg;

    typedef enum logic [3:0] {
        VADD    = 4'd0,
        VSUB    = 4'd1,
        VADC    = 4'd2,
        VAND    = 4'd3,
        VOR     = 4'd4,
        VXOR    = 4'd5,
        VMUL    = 4'd6,
        VMULH   = 4'd7,
        VMULHU  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage : spatz_pkg
`default_nettype wire

// File: rtl/spatz_seq_outreg.sv
`default_nettype none
// ------------------------------------------------------------------------
// spatz_seq_outreg: result register (data, last, valid) holding under stall.
// Rev 1.0
// ------------------------------------------------------------------------
module spatz_seq_outreg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             last_q, last_d;

    // Loading wins over draining so a new element can replace a consumed one.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule : spatz_seq_outreg
`default_nettype wire

// File: rtl/spatz_lane_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// spatz_lane_sequencer: feeds an operand stream through the SIMD lane and
// registers the results. SPATZ_SEQ_PERF_EN enables the stall counter.
// Rev 1.0
// ------------------------------------------------------------------------
module spatz_lane_sequencer
    import spatz_pkg::*;
    import rvv_pkg::*;
#(
    parameter  int unsigned Width = 32,
    parameter  int unsigned MaxVl = 256,
    localparam int unsigned VlW   = $clog2(MaxVl + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  op_e              req_op_i,
    input  logic [VlW-1:0]   req_vl_i,
    input  vew_e             req_sew_i,
    input  logic             req_signed_i,
    input  logic             opd_valid_i,
    output logic             opd_ready_o,
    input  logic [Width-1:0] opd_s1_i,
    input  logic [Width-1:0] opd_s2_i,
    input  logic [Width-1:0] opd_d_i,
    input  logic             opd_carry_i,
    output op_e              lane_op_o,
    output logic [Width-1:0] lane_s1_o,
    output logic [Width-1:0] lane_s2_o,
    output logic [Width-1:0] lane_d_o,
    output logic             lane_signed_o,
    output logic             lane_carry_o,
    output vew_e             lane_sew_o,
    input  logic [Width-1:0] lane_result_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [Width-1:0] res_data_o,
    output logic             res_last_o,
    output logic             done_o,
    output logic [31:0]      perf_stall_o
);

    seq_state_e     state_q, state_d;
    logic [VlW-1:0] cnt_q, cnt_d;
    op_e            op_q, op_d;
    vew_e           sew_q, sew_d;
    logic           signed_q, signed_d;
    logic           done_q, done_d;

    logic req_hs, opd_hs, res_hs;

    assign req_ready_o = (state_q == IDLE);
    assign opd_ready_o = (state_q == RUN) && (!res_valid_o || res_ready_i);
    assign req_hs      = req_valid_i && req_ready_o;
    assign opd_hs      = opd_valid_i && opd_ready_o;
    assign res_hs      = res_valid_o && res_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sew_d    = sew_q;
        signed_d = signed_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    op_d     = req_op_i;
                    sew_d    = req_sew_i;
                    signed_d = req_signed_i;
                    cnt_d    = req_vl_i;
                    if (req_vl_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (opd_hs) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == VlW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Only the final element can be pending here; its handshake ends the request.
                if (res_hs && res_last_o) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= VADD;
            sew_q    <= EW_8;
            signed_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sew_q    <= sew_d;
            signed_q <= signed_d;
            done_q   <= done_d;
        end
    end

    assign done_o        = done_q;
    assign lane_op_o     = op_q;
    assign lane_sew_o    = sew_q;
    assign lane_signed_o = signed_q;
    assign lane_s1_o     = opd_s1_i;
    assign lane_s2_o     = opd_s2_i;
    assign lane_d_o      = opd_d_i;
    assign lane_carry_o  = opd_carry_i;

    spatz_seq_outreg #(
        .Width (Width)
    ) u_outreg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (opd_hs),
        .data_i  (lane_result_i),
        .last_i  (cnt_q == VlW'(1)),
        .ready_i (res_ready_i),
        .valid_o (res_valid_o),
        .data_o  (res_data_o),
        .last_o  (res_last_o)
    );

`ifdef SPATZ_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == RUN) && opd_valid_i && !opd_ready_o && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_o = perf_q;
`else
    assign perf_stall_o = '0;
`endif

    vl_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_hs |-> (req_vl_i <= VlW'(MaxVl)));

endmodule : spatz_lane_sequencer
`default_nettype wire

// File: tb/tb_spatz_lane_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_spatz_lane_sequencer: scoreboard bench for the lane sequencer.
// Rev 1.0
// ------------------------------------------------------------------------
module tb_spatz_lane_sequencer;
    import spatz_pkg::*;
    import rvv_pkg::*;

    localparam int VLW = $clog2(256 + 1);

    logic clk_i = 1'b0;
    logic rst_ni;
    logic req_valid_i, req_ready_o, req_signed_i;
    op_e  req_op_i;
    logic [VLW-1:0] req_vl_i;
    vew_e req_sew_i;
    logic opd_valid_i, opd_ready_o, opd_carry_i;
    logic [31:0] opd_s1_i, opd_s2_i, opd_d_i;
    op_e  lane_op_o;
    logic [31:0] lane_s1_o, lane_s2_o, lane_d_o, lane_result_i;
    logic lane_signed_o, lane_carry_o;
    vew_e lane_sew_o;
    logic res_valid_o, res_ready_i, res_last_o, done_o;
    logic [31:0] res_data_o, perf_stall_o;

    spatz_lane_sequencer #(.Width(32), .MaxVl(256)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_vl_i(req_vl_i), .req_sew_i(req_sew_i), .req_signed_i(req_signed_i),
        .opd_valid_i(opd_valid_i), .opd_ready_o(opd_ready_o), .opd_s1_i(opd_s1_i),
        .opd_s2_i(opd_s2_i), .opd_d_i(opd_d_i), .opd_carry_i(opd_carry_i),
        .lane_op_o(lane_op_o), .lane_s1_o(lane_s1_o), .lane_s2_o(lane_s2_o),
        .lane_d_o(lane_d_o), .lane_signed_o(lane_signed_o), .lane_carry_o(lane_carry_o),
        .lane_sew_o(lane_sew_o), .lane_result_i(lane_result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_last_o(res_last_o), .done_o(done_o), .perf_stall_o(perf_stall_o)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic logic [31:0] lane_fn(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
        logic [63:0] p;
        p = {{32{s & a[31]}}, a} * {{32{s & b[31]}}, b};
        case (op)
            VADD:    return a + b;
            VSUB:    return b - a;
            VADC:    return a + b + {31'd0, c};
            VAND:    return a & b;
            VOR:     return a | b;
            VXOR:    return a ^ b;
            VMUL:    return p[31:0];
            VMULH:   return p[63:32];
            VMULHU:  return 32'(({32'd0, a} * {32'd0, b}) >> 32);
            default: return 32'd0;
        endcase
    endfunction

    // The SIMD lane itself lives in the bench.
    always_comb lane_result_i = lane_fn(lane_op_o, lane_s1_o, lane_s2_o, lane_carry_o, lane_signed_o);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake (t=%0t)", nm, $time);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        q[$];
    int          rem = 0;
    bit          pend = 0;
    op_e         cur_op = VADD;
    logic        cur_sgn = 1'b0;
    vew_e        cur_sew = EW_8;
    logic [31:0] perf_exp = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] log_d[$];
    logic        log_l[$];
    int          log_c[$];

    initial begin
        bit   exp_rr, exp_or;
        exp_t e;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                q.delete();
                rem = 0; pend = 0; perf_exp = 0;
            end else begin
                exp_rr = (rem == 0) && (q.size() == 0);
                exp_or = (rem > 0) && ((q.size() == 0) || res_ready_i);
                check("req_ready", req_ready_o, exp_rr);
                check("opd_ready", opd_ready_o, exp_or);
                check("res_valid", res_valid_o, q.size() > 0);
                if (q.size() > 0) begin
                    check("res_data", res_data_o, q[0].d);
                    check("res_last", res_last_o, q[0].l);
                end
                check("done", done_o, pend);
`ifdef SPATZ_SEQ_PERF_EN
                check("perf_stall", perf_stall_o, perf_exp);
`else
                check("perf_stall", perf_stall_o, 0);
`endif
                check("lane_s1", lane_s1_o, opd_s1_i);
                check("lane_s2", lane_s2_o, opd_s2_i);
                check("lane_d", lane_d_o, opd_d_i);
                check("lane_carry", lane_carry_o, opd_carry_i);
                if (rem > 0) begin
                    check("lane_op", lane_op_o, cur_op);
                    check("lane_signed", lane_signed_o, cur_sgn);
                    check("lane_sew", lane_sew_o, cur_sew);
                end
                if (done_o) done_cnt++;
                if (res_valid_o) rv_cnt++;

                pend = 0;
                if ((rem > 0) && opd_valid_i && (q.size() > 0) && !res_ready_i && (perf_exp != 32'hFFFF_FFFF))
                    perf_exp++;
                if ((q.size() > 0) && res_ready_i) begin
                    e = q.pop_front();
                    if (e.l) pend = 1;
                    log_d.push_back(e.d); log_l.push_back(e.l); log_c.push_back(cyc);
                end
                if (exp_or && opd_valid_i) begin
                    e.d = lane_fn(cur_op, opd_s1_i, opd_s2_i, opd_carry_i, cur_sgn);
                    e.l = (rem == 1);
                    q.push_back(e);
                    rem--;
                end
                if (exp_rr && req_valid_i) begin
                    cur_op = req_op_i; cur_sgn = req_signed_i; cur_sew = req_sew_i;
                    rem = int'(req_vl_i);
                    if (req_vl_i == '0) pend = 1;
                end
            end
        end
    end

    // ---------------- result sink ----------------
    int sink_mode = 0;
    initial begin
        int ph = 0;
        res_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            case (sink_mode)
                0:       res_ready_i = 1'b1;
                1:       begin res_ready_i = (ph == 0); ph = (ph + 1) % 3; end
                default: res_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- drivers ----------------
    logic [31:0] src1[32];
    logic [31:0] src2[32];

    task automatic send_req(input op_e op, input int vl, input logic sgn, output int waited);
        req_valid_i = 1'b1; req_op_i = op; req_vl_i = VLW'(vl); req_signed_i = sgn;
        req_sew_i = vew_e'(2'($urandom_range(0, 3)));
        waited = 0;
        @(negedge clk_i);
        while (!req_ready_o && waited < 1000) begin waited++; @(negedge clk_i); end
        if (!req_ready_o) timeout("req_hs");
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic send_ops(input int n, input int gapmax);
        for (int i = 0; i < n; i++) begin
            if (gapmax > 0) repeat ($urandom_range(0, gapmax)) begin @(posedge clk_i); #1; end
            opd_valid_i = 1'b1; opd_s1_i = src1[i]; opd_s2_i = src2[i];
            opd_d_i = $urandom; opd_carry_i = 1'($urandom_range(0, 1));
            begin
                int t = 0;
                @(negedge clk_i);
                while (!opd_ready_o && t < 1000) begin t++; @(negedge clk_i); end
                if (!opd_ready_o) timeout("opd_hs");
            end
            @(posedge clk_i); #1;
            opd_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk_i);
        while (!(req_ready_o && !res_valid_o) && t < 1000) begin t++; @(negedge clk_i); end
        if (t >= 1000) timeout("idle");
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        log_d.delete(); log_l.delete(); log_c.delete();
        done_cnt = 0; rv_cnt = 0;
    endtask

    task automatic check_vl4_stream(input string nm);
        check({nm, "_count"}, log_d.size(), 4);
        if (log_d.size() == 4) begin
            check({nm, "_d0"}, log_d[0], 32'd11);
            check({nm, "_d1"}, log_d[1], 32'd22);
            check({nm, "_d2"}, log_d[2], 32'd33);
            check({nm, "_d3"}, log_d[3], 32'd44);
            check({nm, "_lasts"}, {log_l[0], log_l[1], log_l[2], log_l[3]}, 4'b0001);
        end
        check({nm, "_done_cnt"}, done_cnt, 1);
    endtask

    op_e ops_tab[9] = '{VADD, VSUB, VADC, VAND, VOR, VXOR, VMUL, VMULH, VMULHU};

    initial begin
        int w;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_op_i = VADD; req_vl_i = '0; req_sew_i = EW_8; req_signed_i = 1'b0;
        opd_valid_i = 1'b0; opd_s1_i = '0; opd_s2_i = '0; opd_d_i = '0; opd_carry_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_res_valid", res_valid_o, 1'b0);
        check("rst_lane_op", lane_op_o, VADD);
        rst_ni = 1'b1;

        // VADD vl=4 with an always-ready sink
        for (int i = 0; i < 4; i++) begin src1[i] = 32'(i + 1); src2[i] = 32'((i + 1) * 10); end
        clear_logs(); sink_mode = 0;
        send_req(VADD, 4, 1'b0, w);
        send_ops(4, 0);
        wait_idle();
        check_vl4_stream("t1");
        if (log_c.size() == 4) check("t1_consecutive", log_c[3] - log_c[0], 3);

        // Same stream with the sink stalling two of every three cycles
        clear_logs(); sink_mode = 1;
        send_req(VADD, 4, 1'b0, w);
        send_ops(4, 0);
        wait_idle();
        check_vl4_stream("t2");
`ifdef SPATZ_SEQ_PERF_EN
        check("t2_perf_nonzero", perf_stall_o != 0, 1'b1);
`endif

        // Zero-length request followed immediately by another
        clear_logs(); sink_mode = 0;
        send_req(VXOR, 0, 1'b0, w);
        send_req(VADD, 0, 1'b0, w);
        check("t3_next_accept_wait", w, 0);
        repeat (3) @(posedge clk_i);
        #1;
        check("t3_done_cnt", done_cnt, 2);
        check("t3_no_results", rv_cnt, 0);

        // Unsigned high multiply
        clear_logs();
        src1[0] = 32'hFFFF_FFFF; src2[0] = 32'd2;
        send_req(VMULHU, 1, 1'b0, w);
        send_ops(1, 0);
        wait_idle();
        check("t4_count", log_d.size(), 1);
        if (log_d.size() == 1) begin
            check("t4_data", log_d[0], 32'h0000_0001);
            check("t4_last", log_l[0], 1'b1);
        end

        // Reset in the middle of a request
        for (int i = 0; i < 4; i++) begin src1[i] = 32'(i + 1); src2[i] = 32'((i + 1) * 10); end
        send_req(VMUL, 4, 1'b1, w);
        send_ops(2, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t5_res_valid", res_valid_o, 1'b0);
        check("t5_res_last", res_last_o, 1'b0);
        check("t5_res_data", res_data_o, 32'd0);
        check("t5_done", done_o, 1'b0);
        check("t5_req_ready", req_ready_o, 1'b1);
        check("t5_opd_ready", opd_ready_o, 1'b0);
        check("t5_lane_op", lane_op_o, VADD);
        check("t5_lane_sew", lane_sew_o, EW_8);
        check("t5_lane_signed", lane_signed_o, 1'b0);
        check("t5_perf", perf_stall_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        clear_logs();
        repeat (5) @(posedge clk_i);
        #1;
        check("t5_no_stale", rv_cnt, 0);

        // Back-to-back requests with req_valid held high
        clear_logs(); sink_mode = 1;
        for (int i = 0; i < 5; i++) begin src1[i] = 32'(100 * i); src2[i] = 32'(i); end
        req_valid_i = 1'b1; req_op_i = VADD; req_vl_i = VLW'(2); req_signed_i = 1'b0; req_sew_i = EW_32;
        @(negedge clk_i);
        if (!req_ready_o) timeout("t6_first");
        @(posedge clk_i); #1;
        req_vl_i = VLW'(3);
        fork
            begin
                int t = 0;
                @(negedge clk_i);
                while (!req_ready_o && t < 1000) begin t++; @(negedge clk_i); end
                if (!req_ready_o) timeout("t6_second");
                @(posedge clk_i); #1;
                req_valid_i = 1'b0;
            end
            send_ops(5, 0);
        join
        wait_idle();
        check("t6_count", log_d.size(), 5);
        if (log_d.size() == 5) begin
            check("t6_lasts", {log_l[0], log_l[1], log_l[2], log_l[3], log_l[4]}, 5'b01001);
            check("t6_d4", log_d[4], 32'd404);
        end
        check("t6_done_cnt", done_cnt, 2);

        // Randomised requests, gaps and backpressure
        sink_mode = 2;
        for (int r = 0; r < 30; r++) begin
            int vl;
            vl = $urandom_range(0, 10);
            for (int i = 0; i < 32; i++) begin src1[i] = $urandom; src2[i] = $urandom; end
            send_req(ops_tab[$urandom_range(0, 8)], vl, 1'($urandom_range(0, 1)), w);
            send_ops(vl, 2);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spatz_lane_sequencer
`default_nettype wire
